// File: rtl/pwm_symbol_encoder.sv
// PWM symbol encoder: one symbol in, a constant-amplitude pulse of
// (sym+1)*UNIT_LEN samples followed by GAP_LEN zero samples out.
module pwm_symbol_encoder #(
  parameter int unsigned      UNIT_LEN   = 8,
  parameter int unsigned      GAP_LEN    = 16,
  parameter logic signed [15:0] AMPLITUDE = 16'sd256,
  parameter int               MAX_SYMBOL = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [7:0]  symbol_in,
  input  logic               symbol_valid,
  output logic               symbol_ready,
  output logic signed [15:0] data_out,
  output logic               data_valid,
  output logic               sym_error,
  output logic [15:0]        symbol_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [15:0]       UNIT_CNT = 16'(UNIT_LEN);
  localparam logic [15:0]       GAP_CNT  = 16'(GAP_LEN);
  localparam logic signed [7:0] MAX_SYM  = 8'(MAX_SYMBOL);

  state_t             state;
  state_t             state_d;
  logic [15:0]        cnt;
  logic [15:0]        cnt_d;
  logic signed [15:0] data_d;
  logic [15:0]        count_d;
  logic [7:0]         sym_clamped;
  logic               clamp_err;
  logic [15:0]        pulse_len;
  logic               last;
  logic               accept;

  always_comb begin
    sym_clamped = symbol_in;
    clamp_err   = 1'b0;
    if (symbol_in[7]) begin
      sym_clamped = 8'd0;
      clamp_err   = 1'b1;
    end else if (symbol_in > MAX_SYM) begin
      sym_clamped = MAX_SYM;
      clamp_err   = 1'b1;
    end
  end

  assign pulse_len = (16'(sym_clamped) + 16'd1) * UNIT_CNT;

  // Final gap sample consumed this cycle: the slot where a
  // following symbol can start without an idle cycle.
  assign last = enable && (cnt == 16'd1);

  assign symbol_ready = !reset &&
    ((state == IDLE) || ((state == GAP) && last));

  assign accept     = symbol_valid && symbol_ready;
  assign data_valid = enable && (state != IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = data_out;
    count_d = symbol_count;
    unique case (state)
      IDLE: begin
        data_d = 16'sd0;
        if (accept) begin
          state_d = PULSE;
          cnt_d   = pulse_len;
          data_d  = AMPLITUDE;
        end
      end
      PULSE: begin
        if (enable) begin
          if (cnt == 16'd1) begin
            state_d = GAP;
            cnt_d   = GAP_CNT;
            data_d  = 16'sd0;
          end else begin
            cnt_d = cnt - 16'd1;
          end
        end
      end
      GAP: begin
        if (enable) begin
          if (cnt == 16'd1) begin
            count_d = symbol_count + 16'd1;
            if (accept) begin
              state_d = PULSE;
              cnt_d   = pulse_len;
              data_d  = AMPLITUDE;
            end else begin
              state_d = IDLE;
              cnt_d   = 16'd0;
              data_d  = 16'sd0;
            end
          end else begin
            cnt_d = cnt - 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        data_d  = 16'sd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      data_out     <= 16'sd0;
      sym_error    <= 1'b0;
      symbol_count <= 16'd0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      data_out     <= data_d;
      sym_error    <= accept && clamp_err;
      symbol_count <= count_d;
    end
  end

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Directed bench for pwm_symbol_encoder at default parameters.
// Expected sample streams are built from symbol values by the bench.
module tb_pwm_symbol_encoder;

  localparam int UNIT = 8;
  localparam int GAPL = 16;
  localparam int AMP  = 256;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic signed [7:0]  symbol_in = '0;
  logic               symbol_valid = 1'b0;
  logic               symbol_ready;
  logic signed [15:0] data_out;
  logic               data_valid;
  logic               sym_error;
  logic [15:0]        symbol_count;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];
  int got_q[$];
  int err_cycles = 0;

  pwm_symbol_encoder dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
    .symbol_ready (symbol_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sym_error    (sym_error),
    .symbol_count (symbol_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (!reset && sym_error) err_cycles++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic add_sym(input int sym);
    for (int i = 0; i < (sym + 1) * UNIT; i++) exp_q.push_back(AMP);
    for (int i = 0; i < GAPL; i++) exp_q.push_back(0);
  endtask

  function automatic int mism();
    int m = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] != exp_q[i]) m++;
    return m;
  endfunction

  task automatic offer(input logic signed [7:0] s, input bit exp_err);
    int n = 0;
    symbol_in    = s;
    symbol_valid = 1'b1;
    while (!symbol_ready && n < 2000) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("accept", 32'(n < 2000), 1);
    @(posedge clock);
    #1;
    symbol_valid = 1'b0;
    check("sym_err", 32'(sym_error), 32'(exp_err));
  endtask

  task automatic collect(input int max_cyc, input bit toggle,
                         output int gaps, output int hold_bad,
                         output int rdy_hits);
    bit started = 0;
    bit prev_en = 1;
    logic signed [15:0] prev_d = '0;
    got_q.delete();
    gaps = 0;
    hold_bad = 0;
    rdy_hits = 0;
    for (int c = 0; c < max_cyc && got_q.size() < exp_q.size(); c++) begin
      @(negedge clock);
      enable = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (started && !prev_en && data_out !== prev_d) hold_bad++;
      if (data_valid) begin
        got_q.push_back(int'(data_out));
        started = 1;
        if (symbol_ready) rdy_hits++;
      end else if (started) begin
        gaps++;
      end
      prev_en = enable;
      prev_d  = data_out;
    end
    enable = 1'b1;
  endtask

  initial begin
    int gaps, hold, rh, e0;

    repeat (3) @(negedge clock);
    check("rst_ready", 32'(symbol_ready), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_err", 32'(sym_error), 0);
    check("rst_count", 32'(symbol_count), 0);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(symbol_ready), 1);

    // symbol 9
    exp_q.delete();
    add_sym(9);
    e0 = err_cycles;
    offer(9, 0);
    collect(400, 0, gaps, hold, rh);
    check("t1_len", 32'(got_q.size()), 96);
    check("t1_data", 32'(mism()), 0);
    check("t1_rdy_last", 32'(rh), 1);
    @(negedge clock);
    #1;
    check("t1_idle_valid", 32'(data_valid), 0);
    check("t1_idle_ready", 32'(symbol_ready), 1);
    check("t1_idle_data", 32'(data_out), 0);
    check("t1_count", 32'(symbol_count), 1);
    check("t1_no_err", 32'(err_cycles - e0), 0);

    // 0 and 15 back to back
    exp_q.delete();
    add_sym(0);
    add_sym(15);
    fork
      begin
        offer(0, 0);
        offer(15, 0);
      end
      collect(600, 0, gaps, hold, rh);
    join
    check("t2_len", 32'(got_q.size()), 168);
    check("t2_data", 32'(mism()), 0);
    check("t2_no_idle", 32'(gaps), 0);
    check("t2_rdy", 32'(rh), 2);
    @(negedge clock);
    #1;
    check("t2_count", 32'(symbol_count), 3);

    // symbol 3 with alternating enable
    exp_q.delete();
    add_sym(3);
    offer(3, 0);
    collect(400, 1, gaps, hold, rh);
    check("t3_len", 32'(got_q.size()), 48);
    check("t3_data", 32'(mism()), 0);
    check("t3_stalls", 32'(gaps), 47);
    check("t3_hold", 32'(hold), 0);
    check("t3_rdy", 32'(rh), 1);
    @(negedge clock);
    #1;
    check("t3_count", 32'(symbol_count), 4);

    // clamping
    e0 = err_cycles;
    exp_q.delete();
    add_sym(0);
    offer(-8'sd5, 1);
    collect(400, 0, gaps, hold, rh);
    check("t4_neg_len", 32'(got_q.size()), 24);
    check("t4_neg_data", 32'(mism()), 0);
    exp_q.delete();
    add_sym(15);
    offer(8'sd40, 1);
    collect(400, 0, gaps, hold, rh);
    check("t4_big_len", 32'(got_q.size()), 144);
    check("t4_big_data", 32'(mism()), 0);
    @(negedge clock);
    #1;
    check("t4_err_pulses", 32'(err_cycles - e0), 2);
    check("t4_count", 32'(symbol_count), 6);

    // reset in the middle of symbol 7
    offer(7, 0);
    repeat (20) @(negedge clock);
    #1;
    check("t5_pre_data", 32'(data_out), 32'(AMP));
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("t5_rst_data", 32'(data_out), 0);
    check("t5_rst_count", 32'(symbol_count), 0);
    check("t5_rst_ready", 32'(symbol_ready), 0);
    reset = 1'b0;
    #1;
    check("t5_rel_ready", 32'(symbol_ready), 1);
    exp_q.delete();
    add_sym(1);
    offer(1, 0);
    collect(400, 0, gaps, hold, rh);
    check("t5_len", 32'(got_q.size()), 32);
    check("t5_data", 32'(mism()), 0);
    @(negedge clock);
    #1;
    check("t5_count", 32'(symbol_count), 1);

    // counter wrap from 65535 completed symbols
    force dut.symbol_count = 16'hffff;
    @(posedge clock);
    #1;
    release dut.symbol_count;
    @(negedge clock);
    #1;
    check("t6_preload", 32'(symbol_count), 32'hffff);
    exp_q.delete();
    add_sym(0);
    offer(0, 0);
    collect(400, 0, gaps, hold, rh);
    check("t6_data", 32'(mism()), 0);
    @(negedge clock);
    #1;
    check("t6_wrap", 32'(symbol_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
